rf_write_arbiter: RTL



---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_write_arbiter_if.sv | 42 ++++
 rtl/rf_write_arbiter_pick.sv | 55 +++++
 rtl/rf_write_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and sizing constants.
// Used by the write arbiter (and the read-side selector), so that source masks
// and physical-register indices have one definition across both sides.
package rf_pkg;

  localparam int NUM_SRC   = 6;
  localparam int NUM_PORTS = 2;
  localparam int PREG_W    = 6;
  localparam int DATA_W    = 32;
  localparam int PTR_W     = $clog2(NUM_SRC);

  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [NUM_SRC-1:0]   src_mask_t;
  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [PTR_W-1:0]     ptr_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between execution sources and the register-file write arbiter.
//
// Handshake: source i offers a result by raising i_wb_valid[i] with
// i_wb_preg[i]/i_wb_data[i]; the offer transfers on a rising clock edge where
// i_wb_valid[i] && o_wb_ready[i]. While valid is high and ready is low, the
// source holds valid, preg and data stable. o_wb_ready does not depend on
// i_wb_valid.
//
// Signals:
//   i_wb_valid  per-source offer
//   i_wb_preg   per-source destination physical register
//   i_wb_data   per-source result data
//   o_wb_ready  per-source acceptance
//   o_rf_we     per-port RF write enable (registered)
//   o_rf_waddr  per-port RF write address (registered, 0 when unused)
//   o_rf_wdata  per-port RF write data (registered, 0 when unused)
//   o_done_mask per-source one-cycle retire pulse (registered)
interface rf_write_arbiter_if;
  import rf_pkg::*;

  src_mask_t                 i_wb_valid;
  preg_t [NUM_SRC-1:0]       i_wb_preg;
  data_t [NUM_SRC-1:0]       i_wb_data;
  src_mask_t                 o_wb_ready;
  port_mask_t                o_rf_we;
  preg_t [NUM_PORTS-1:0]     o_rf_waddr;
  data_t [NUM_PORTS-1:0]     o_rf_wdata;
  src_mask_t                 o_done_mask;

  // Producer side (execution units / bench).
  modport master (
    output i_wb_valid, i_wb_preg, i_wb_data,
    input  o_wb_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_done_mask
  );

  // Arbiter side.
  modport slave (
    input  i_wb_valid, i_wb_preg, i_wb_data,
    output o_wb_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_done_mask
  );

endinterface

// File: rtl/rf_write_arbiter_pick.sv
// rr_multi_pick: combinational round-robin picker granting up to P requesters.
// Scans req_i starting at ptr_i, wrapping mod N. The k-th hit gets grant
// vector k (one-hot). Usable for both the write and read sides.
//
// Ports:
//   req_i      request mask
//   ptr_i      scan start index
//   gnt_o      P one-hot grant vectors, index = port
//   found_o    per-port "a requester was assigned"
//   next_ptr_o index after the last assigned requester (ptr_i if none)
module rr_multi_pick #(
  parameter int N = rf_pkg::NUM_SRC,
  parameter int P = rf_pkg::NUM_PORTS
) (
  input  logic [N-1:0]              req_i,
  input  logic [$clog2(N)-1:0]      ptr_i,
  output logic [P-1:0][N-1:0]       gnt_o,
  output logic [P-1:0]              found_o,
  output logic [$clog2(N)-1:0]      next_ptr_o
);

  localparam int PW = $clog2(N);
  localparam int SW = PW + 1;
  localparam int CW = $clog2(P + 1);

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;
  logic [CW-1:0] cnt;

  always_comb begin
    gnt_o      = '0;
    found_o    = '0;
    next_ptr_o = ptr_i;
    sum        = '0;
    idx        = '0;
    cnt        = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k < 2N, so one conditional subtract is enough to wrap.
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[PW-1:0];
      if (req_i[idx] && (cnt < CW'(P))) begin
        for (int p = 0; p < P; p++) begin
          if (cnt == CW'(p)) begin
            gnt_o[p][idx] = 1'b1;
            found_o[p]    = 1'b1;
          end
        end
        cnt        = cnt + CW'(1);
        next_ptr_o = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: collects writeback results from NUM_SRC sources into
// one-entry holding registers and issues them to NUM_PORTS RF write ports
// with round-robin fairness. Entries targeting physical register 0 retire
// without using a port. Port outputs and the done mask are registered and
// appear on the edge after the grant.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    writeback/RF-write bundle (slave side)
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rf_write_arbiter_if.slave    bus
);

  // Holding registers.
  src_mask_t               full_q, full_d;
  preg_t [NUM_SRC-1:0]     preg_q, preg_d;
  data_t [NUM_SRC-1:0]     data_q, data_d;
  ptr_t                    rr_ptr_q, rr_ptr_d;

  // Output registers.
  port_mask_t              we_q, we_d;
  preg_t [NUM_PORTS-1:0]   waddr_q, waddr_d;
  data_t [NUM_PORTS-1:0]   wdata_q, wdata_d;
  src_mask_t               done_q, done_d;

  // Pick results.
  src_mask_t               zero_hit, pick_req, grant, ready, xfer;
  src_mask_t [NUM_PORTS-1:0] port_gnt;
  port_mask_t              port_found;
  ptr_t                    next_ptr;

  // Zero-preg entries retire for free and stay out of the port scan.
  always_comb begin
    zero_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      zero_hit[i] = full_q[i] && (preg_q[i] == '0);
    end
    pick_req = full_q & ~zero_hit;
  end

  rr_multi_pick #(
    .N (NUM_SRC),
    .P (NUM_PORTS)
  ) u_pick (
    .req_i      (pick_req),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (port_gnt),
    .found_o    (port_found),
    .next_ptr_o (next_ptr)
  );

  always_comb begin
    grant = zero_hit;
    for (int p = 0; p < NUM_PORTS; p++) begin
      grant = grant | port_gnt[p];
    end
    ready = ~full_q | grant;
    xfer  = bus.i_wb_valid & ready;
  end

  assign bus.o_wb_ready  = ready;
  assign bus.o_rf_we     = we_q;
  assign bus.o_rf_waddr  = waddr_q;
  assign bus.o_rf_wdata  = wdata_q;
  assign bus.o_done_mask = done_q;

  // Holding-register next state: a refill wins over a grant, so a granted
  // entry that is reloaded in the same cycle stays full.
  always_comb begin
    full_d = full_q;
    preg_d = preg_q;
    data_d = data_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer[i]) begin
        full_d[i] = 1'b1;
        preg_d[i] = bus.i_wb_preg[i];
        data_d[i] = bus.i_wb_data[i];
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
      end
    end
    rr_ptr_d = port_found[0] ? next_ptr : rr_ptr_q;
  end

  // Port muxes: grants are one-hot, so AND-OR selection leaves unused ports at 0.
  always_comb begin
    we_d    = port_found;
    waddr_d = '0;
    wdata_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (port_gnt[p][i]) begin
          waddr_d[p] = waddr_d[p] | preg_q[i];
          wdata_d[p] = wdata_d[p] | data_q[i];
        end
      end
    end
    done_d = grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q   <= '0;
      preg_q   <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= '0;
    end else begin
      full_q   <= full_d;
      preg_q   <= preg_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

endmodule
